// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the single-wire serial link
//                (frame state encoding and default bit-rate constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Frame state, shared with the future receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } serial_state_e;

    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage
`default_nettype wire

// File: rtl/serial_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_timer
//  Description : Counts 0..CLKS_PER_BIT-1 and flags the terminal count.
//                A clear forces the count back to zero on the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_timer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: wrap at terminal count, restart on clear
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Parallel-to-serial transmitter. Accepts a word over a
//                valid/ready handshake and sends start bit, data LSB first,
//                stop bit, each held CLKS_PER_BIT cycles. txd is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              busy,
    output logic              txd
);

    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    serial_state_e     state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              txd_q, txd_d;
    logic              tick;
    logic              timer_clear;
    logic [DATA_W-1:0] shifted;

    // Timer held at zero while idle and restarted on every bit boundary,
    // so each new state (or shifted bit) begins with a full bit period.
    assign timer_clear = (state_q == ST_IDLE) || tick;
    assign shifted     = shift_q >> 1;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (timer_clear),
        .tick   (tick)
    );

    assign ready = (state_q == ST_IDLE);
    assign busy  = !ready;
    assign txd   = txd_q;

    // Next-state, shift register, bit index and next txd value
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (valid) begin
                    shift_d = data_in;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shifted;
                        txd_d   = shifted[0];
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    txd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Self-checking bench for serial_tx (C=4 and C=1 instances)
//                against a frame-level bit-stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    localparam int DW = 8;
    localparam int C  = 4;
    localparam int FL = (DW + 2) * C;

    logic          clock = 1'b0;
    logic          resetn;
    logic [DW-1:0] data_in, data_in1;
    logic          valid, valid1;
    wire           ready, busy, txd;
    wire           ready1, busy1, txd1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    serial_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .txd     (txd)
    );

    serial_tx #(.CLKS_PER_BIT(1), .DATA_W(DW)) dut1 (
        .clock   (clock),
        .resetn  (resetn),
        .data_in (data_in1),
        .valid   (valid1),
        .ready   (ready1),
        .busy    (busy1),
        .txd     (txd1)
    );

    // Line value of frame slot j: start, data LSB first, stop
    function automatic logic frame_bit(input logic [DW-1:0] w, input int j);
        if (j == 0) return 1'b0;
        if (j <= DW) return w[j-1];
        return 1'b1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_val({tag, "_txd"},   txd,   1);
            check_val({tag, "_ready"}, ready, 1);
            check_val({tag, "_busy"},  busy,  0);
            @(negedge clock);
        end
    endtask

    // Present one word for a single cycle; returns at the negedge after acceptance
    task automatic offer(input logic [DW-1:0] w);
        check_val("offer_ready", ready, 1);
        valid   = 1'b1;
        data_in = w;
        @(negedge clock);
        valid   = 1'b0;
    endtask

    // mode 0: inputs untouched, 1: random input noise, 2: 3C pulse in data bit 2
    task automatic frame_check(input logic [DW-1:0] w, input int mode, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            check_val($sformatf("txd[%0d]", i), txd, frame_bit(w, i / C));
            check_val($sformatf("ready[%0d]", i), ready, 0);
            check_val($sformatf("busy[%0d]", i), busy, 1);
            if (mode == 1) begin
                data_in = DW'($urandom);
                valid   = (i < FL - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (mode == 2) begin
                if (i == 3 * C) begin
                    valid   = 1'b1;
                    data_in = 8'h3C;
                end else if (i == 3 * C + 1) begin
                    valid   = 1'b0;
                    data_in = 8'hC3;
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic frame_c1(input logic [DW-1:0] w);
        check_val("c1_ready_pre", ready1, 1);
        valid1   = 1'b1;
        data_in1 = w;
        @(negedge clock);
        valid1   = 1'b0;
        data_in1 = ~w;
        for (int i = 0; i < DW + 2; i++) begin
            check_val($sformatf("c1_txd[%0d]", i), txd1, frame_bit(w, i));
            check_val($sformatf("c1_ready[%0d]", i), ready1, 0);
            @(negedge clock);
        end
        check_val("c1_ready_end", ready1, 1);
        check_val("c1_txd_end", txd1, 1);
        check_val("c1_busy_end", busy1, 0);
    endtask

    initial begin
        logic [DW-1:0] w;

        // Reset held with valid asserted: must stay idle
        resetn   = 1'b0;
        valid    = 1'b1;
        data_in  = DW'($urandom);
        valid1   = 1'b1;
        data_in1 = DW'($urandom);
        @(negedge clock);
        check_idle("rst", 5);
        valid  = 1'b0;
        valid1 = 1'b0;
        resetn = 1'b1;
        check_idle("post_rst", 3);

        // Single frame A5
        offer(8'hA5);
        frame_check(8'hA5, 0, FL);
        check_idle("a5_end", 3);

        // Random frames with input noise during the frame
        repeat (4) begin
            w = DW'($urandom);
            offer(w);
            frame_check(w, 1, FL);
            check_idle("rnd_end", 2);
        end

        // Ignored input during data bit 2 of 5A, no follow-on frame
        offer(8'h5A);
        frame_check(8'h5A, 2, FL);
        check_idle("ign_end", FL + 2);

        // Back-to-back with valid held high
        valid   = 1'b1;
        data_in = 8'h00;
        @(negedge clock);
        data_in = 8'hFF;
        frame_check(8'h00, 0, FL);
        check_val("gap_ready", ready, 1);
        check_val("gap_txd", txd, 1);
        @(negedge clock);
        valid = 1'b0;
        frame_check(8'hFF, 0, FL);
        check_idle("b2b_end", 2);

        // Mid-frame reset during data bit 3 of F0
        offer(8'hF0);
        frame_check(8'hF0, 0, 4 * C + 1);
        #2;
        resetn = 1'b0;
        #1;
        check_val("mrst_txd", txd, 1);
        check_val("mrst_ready", ready, 1);
        check_val("mrst_busy", busy, 0);
        @(negedge clock);
        check_idle("mrst_hold", 2);
        resetn = 1'b1;
        check_idle("mrst_rel", 1);
        offer(8'h01);
        frame_check(8'h01, 0, FL);
        check_idle("mrst_end", 2);

        // One-cycle bits
        frame_c1(8'h81);
        @(negedge clock);
        repeat (3) begin
            frame_c1(DW'($urandom));
            @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
